// File: rtl/cpu4510_map_bus.sv
// 4510 MAP translation of the core's next address to 20-bit physical, registered bus outputs with 1-cycle latency.
// Slow-page accesses drop the registered ready for WAIT_CYCLES cycles when MAP_WAITSTATE_EN is defined; otherwise ready is tied high.
module cpu4510_map_bus #(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [7:0] SLOW_PAGE   = 8'h0D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_o_next,
    input  logic        map,
    input  logic        hyper_mode,
    input  logic [7:0]  a_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [7:0]  z_in,
    output logic        ready,
    output logic [19:0] phys_addr_next,
    output logic [19:0] phys_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [15:0] map_lo,
    output logic [15:0] map_hi
);

    logic [11:0] lo_off_q, hi_off_q;
    logic [3:0]  lo_en_q, hi_en_q;
    logic [19:0] phys_addr_q;
    logic        mem_we_q;
    logic [7:0]  mem_wdata_q;

    logic [2:0]  blk;
    logic        blk_en;
    logic [11:0] blk_off;

    assign blk     = address_next[15:13];
    assign blk_en  = blk[2] ? hi_en_q[blk[1:0]] : lo_en_q[blk[1:0]];
    assign blk_off = blk[2] ? hi_off_q : lo_off_q;

    // The 20-bit add wraps naturally modulo 2^20.
    assign phys_addr_next = (blk_en && !hyper_mode)
                          ? ({4'h0, address_next} + {blk_off, 8'h00})
                          : {4'h0, address_next};

    always_ff @(posedge clk) begin
        if (!reset) begin
            lo_off_q    <= '0;
            hi_off_q    <= '0;
            lo_en_q     <= '0;
            hi_en_q     <= '0;
            phys_addr_q <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else if (ready) begin
            if (map) begin
                lo_off_q <= {x_in[3:0], a_in};
                lo_en_q  <= x_in[7:4];
                hi_off_q <= {z_in[3:0], y_in};
                hi_en_q  <= z_in[7:4];
            end
            phys_addr_q <= phys_addr_next;
            mem_we_q    <= write_next;
            mem_wdata_q <= data_o_next;
        end
    end

    assign phys_addr = phys_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign map_lo    = {lo_en_q, lo_off_q};
    assign map_hi    = {hi_en_q, hi_off_q};

`ifdef MAP_WAITSTATE_EN
    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_RUN: begin
                // The edge that latches a slow address is the one that drops ready.
                if (phys_addr_next[19:12] == SLOW_PAGE && WAIT_CYCLES != 0) begin
                    wcnt_d  = 4'(WAIT_CYCLES);
                    ready_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    ready_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready = ready_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{SLOW_PAGE, 4'(WAIT_CYCLES)};
    assign ready      = 1'b1;
`endif

endmodule

// File: doc/cpu4510_map_bus.md
# cpu4510_map_bus

Bus-side translation stage directly downstream of the `cpu65CE02` core. It converts the core's 16-bit `address_next` into a 20-bit physical address using the 4510 MAP registers. Those registers are captured from A/X/Y/Z when the core's microcode asserts `map`. The stage also generates the core's registered `ready`, inserting wait states for a slow physical page. Memory and I/O decoders consume its physical address, write strobe and write data.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: ready-low cycles per slow-page access (0..15).
- `SLOW_PAGE`, 8'h0D: physical `[19:12]` page that takes wait states.

Ports:
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-low.
- `address_next`  in  16  core's next address.
- `write_next`  in  1  core's next write strobe.
- `data_o_next`  in  8  core's next write data.
- `map`  in  1  microcode MAP strobe.
- `hyper_mode`  in  1  core is in hypervisor mode.
- `a_in`, `x_in`, `y_in`, `z_in`  in  8 each  core A/X/Y/Z register values.
- `ready`  out  1  registered ready to the core.
- `phys_addr_next`  out  20  combinational translation of `address_next`.
- `phys_addr`  out  20  registered physical address.
- `mem_we`  out  1  registered write strobe.
- `mem_wdata`  out  8  registered write data.
- `map_lo`  out  16  `{enables[3:0], offset[11:0]}` for blocks 0-3, debug.
- `map_hi`  out  16  `{enables[3:0], offset[11:0]}` for blocks 4-7, debug.

## Operation
- MAP capture: on a clock where `map & ready`:
  - lo_off <= {x_in[3:0], a_in}; lo_en <= x_in[7:4]. Bit n enables block n.
  - hi_off <= {z_in[3:0], y_in}; hi_en <= z_in[7:4]. Bit n enables block 4+n.
- Translation:
  - block = `address_next[15:13]`.
  - If the block's enable bit is set and `hyper_mode`=0: `phys_addr_next` = {4'h0, address_next} + {off, 8'h00}, truncated to 20 bits (wraps mod 2^20).
  - Otherwise: `phys_addr_next` = {4'h0, address_next}.
- Registering: when `ready`=1, `phys_addr`, `mem_we` and `mem_wdata` load `phys_addr_next`, `write_next` and `data_o_next`. When `ready`=0 they hold.
- Wait FSM (states RUN and WAIT; 4-bit counter `wcnt`):
  - RUN, `ready`=1: if `phys_addr_next[19:12]`==`SLOW_PAGE` and `WAIT_CYCLES`≠0, then `wcnt`<=`WAIT_CYCLES`, `ready`<=0, go to WAIT. Otherwise stay in RUN.
  - WAIT: `wcnt` decrements each cycle. When `wcnt`==1, `ready`<=1 and return to RUN.
  - Back-to-back slow accesses each take the full wait.
- Simultaneous events:
  - `map` with a slow access: MAP is captured; the wait still applies to the address latched on that edge.
  - `map` while `ready`=0: ignored. The core holds `map` until ready.
- Reset (`reset`=0), including mid-WAIT:
  - State RUN, `ready`=1, `wcnt`=0.
  - lo/hi offsets and enables = 0.
  - `phys_addr`=0, `mem_we`=0, `mem_wdata`=0.

## Timing
- `phys_addr_next` is combinational from `address_next`, `hyper_mode` and the MAP registers. There is no path from `ready` into it other than through `address_next`.
- `ready` is registered, so there is no combinational loop with the core's `address_next` mux.
- New MAP values affect `phys_addr_next` from the cycle after the capture edge.
- Slow access: the edge that latches the address drops `ready`. `ready` stays low for exactly `WAIT_CYCLES` cycles, then rises.
- Fast access: zero added latency.

## Configuration
- `MAP_WAITSTATE_EN` defined: wait FSM present as described above.
- `MAP_WAITSTATE_EN` undefined:
  - FSM and counter are omitted; `ready` is tied to 1 (still 1 during reset).
  - `SLOW_PAGE` and `WAIT_CYCLES` are ignored.
  - Translation is unchanged.

## Test plan
- Reset then `address_next`=16'h1234, `write_next`=0 -> `phys_addr_next`=20'h01234; after one edge `phys_addr`=20'h01234, `ready`=1, `map_lo`=`map_hi`=0.
- `map` pulse with A=8'h40, X=8'h30, Y=0, Z=0 -> `map_lo`=16'h3040. Then `address_next`=16'h1234 -> 20'h05234; 16'h4000 (block 2, disabled) -> 20'h04000.
- `map` with Y=8'hFF, Z=8'h8F, then `address_next`=16'hE100 -> 20'h0E000 (wraps mod 2^20). With `hyper_mode`=1 -> 20'h0E100.
- `MAP_WAITSTATE_EN` defined, `WAIT_CYCLES`=2, identity map, `address_next`=16'hD020 -> `ready` low for exactly 2 cycles; `phys_addr`=20'h0D020 held throughout. `write_next`=1 with data 8'h5A -> `mem_we`=1 and `mem_wdata`=8'h5A held for 3 cycles.
- Assert `reset`=0 during the first WAIT cycle -> next edge `ready`=1, `phys_addr`=0, map registers cleared.
- `MAP_WAITSTATE_EN` undefined, `address_next`=16'hD020 -> `ready` stays 1 on every cycle.
